conv_output_streamer: RTL
=========================

Name: conv_output_streamer

Overview:
- Reader/consumer end of the flat feature-map bus driven by the multi-filter convolution layer.
- Walks the K x OH x OW output volume held on the wide bus and emits one DATA_WIDTH element per transfer over a valid/ready stream.
- Emits row, map and volume boundary flags so the downstream layer (pooling or fully-connected) can consume outputs serially instead of through a full-width bus.

Parameters:
- DATA_WIDTH, 16, bits per feature-map element (signed fixed-point, passed through untouched)
- K, 6, number of feature maps (filters) on the bus
- OH, 28, output map height (H-F+1)
- OW, 28, output map width (W-F+1)
- CHAN_W, 3, width of out_chan; must satisfy 2^CHAN_W >= K

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to stream the volume currently on fmap
- fmap  input  K*OH*OW*DATA_WIDTH  feature-map bus, declared [0:K*OH*OW*DATA_WIDTH-1]; element e occupies bits [e*DATA_WIDTH +: DATA_WIDTH], e = k*OH*OW + r*OW + c
- busy  output  1  high from the cycle after start is accepted until the final transfer completes
- out_data  output  DATA_WIDTH  current element
- out_valid  output  1  out_data and flags are valid
- out_ready  input  1  downstream accepts the element this cycle
- out_chan  output  CHAN_W  map index k of the current element
- out_last_row  output  1  current element has c == OW-1
- out_last_map  output  1  current element has r == OH-1 and c == OW-1
- out_last  output  1  current element is the final one (k == K-1, last of map)
- done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (synchronous, checked first on every edge): state IDLE; out_valid, busy, done, out_last_row, out_last_map, out_last = 0; out_data = 0; out_chan = 0; counters k, r, c = 0. Reset mid-stream aborts immediately with no done pulse; the partial stream is not resumed.
- States: IDLE, STREAM, FINISH.
- IDLE: start = 1 -> STREAM. On that same edge, load k=r=c=0, out_data = element 0, flags for element 0, out_valid = 1, busy = 1. Latency from start to first out_valid is 1 cycle.
- STREAM:
  - Transfer occurs on any edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_chan and all flags hold stable (standard no-retract rule).
  - On a transfer of a non-final element, advance c; on c == OW-1, wrap c to 0 and increment r; on r == OH-1, wrap r to 0 and increment k. The next element and its flags are registered in the same edge, so back-to-back transfers sustain 1 element/cycle.
  - On the transfer of the final element (out_last = 1): out_valid = 0, busy = 0, all flags = 0, done = 1 next cycle; go to FINISH.
- FINISH: done = 1 for exactly this one cycle, then IDLE. A start arriving during FINISH is ignored.
- start is ignored while busy or in FINISH; there is no queuing.
- fmap is not captured. The producer holds it stable from the start cycle until done. Changing fmap mid-stream is a protocol error and out_data follows the new bus contents.
- Element selection is an indexed part-select at element index k*OH*OW + r*OW + c. The index is held in a registered counter so no multiplier sits in the datapath.
- Flags are computed from the next-element counters and registered with out_data. Single-element corner cases are exact: with OW=1, out_last_row is always 1; with OH=OW=1, out_last_map is always 1; with K=OH=OW=1, out_last is 1 on the only element.
- Total transfers per start: exactly K*OH*OW.

Test Plan:
- Use K=2, OH=2, OW=3, DATA_WIDTH=16, with fmap element e = 16'h0100+e. Pulse start, hold out_ready=1 -> out_valid rises 1 cycle after start. 12 consecutive transfers of 0x0100..0x010B. out_chan is 0 for the first 6 and 1 for the last 6. out_last_row on e=2,5,8,11; out_last_map on e=5,11; out_last only on e=11. done pulses exactly 1 cycle after e=11; busy is low the same cycle.
- Same setup, out_ready toggled 1,0,0,1 repeatedly -> no element duplicated or dropped; out_data and flags stable during every stall; 12 transfers total; done follows the last handshake by 1 cycle.
- Second start pulse asserted mid-stream and during the FINISH cycle -> ignored; stream still ends after 12 transfers with a single done pulse.
- Reset asserted after 4 transfers -> next cycle out_valid=0, busy=0, done=0, out_data=0. A following start restarts at element 0 (0x0100).
- Negative data (fmap element = 16'hFFF0) -> streamed bit-exact, no sign change.
- K=1, OH=1, OW=1 -> single transfer with out_last_row=out_last_map=out_last=1, followed by a done pulse.

Source files
------------

// File: rtl/conv_output_streamer.sv
// conv_output_streamer: walks the K x OH x OW feature-map volume held on a
// wide flat bus and emits one element per valid/ready transfer. Each element
// carries its map index and row/map/volume boundary flags.
module conv_output_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int K          = 6,
    parameter int OH         = 28,
    parameter int OW         = 28,
    parameter int CHAN_W     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [0:K*OH*OW*DATA_WIDTH-1] fmap,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHAN_W-1:0]             out_chan,
    output logic                          out_last_row,
    output logic                          out_last_map,
    output logic                          out_last,
    output logic                          done
);

    localparam int N      = K * OH * OW;
    localparam int BITS   = N * DATA_WIDTH;
    localparam int BASE_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int CW     = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW     = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CW-1:0]     C_MAX    = CW'(OW - 1);
    localparam logic [RW-1:0]     R_MAX    = RW'(OH - 1);
    localparam logic [CHAN_W-1:0] K_MAX    = CHAN_W'(K - 1);
    localparam logic [BASE_W-1:0] BASE_INC = BASE_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   k_q, k_d;
    logic [RW-1:0]       r_q, r_d;
    logic [CW-1:0]       c_q, c_d;
    // Bit offset of the current element on the bus; stepping it by
    // DATA_WIDTH per transfer keeps the k*OH*OW + r*OW + c product out of
    // the datapath.
    logic [BASE_W-1:0]   base_q, base_d;
    logic                last_row_q, last_row_d;
    logic                last_map_q, last_map_d;
    logic                last_q, last_d;
    logic                stream_d;

    // Next-state, counter advance and next-element flag computation.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        base_d  = base_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    base_d  = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = S_FINISH;
                        k_d     = '0;
                        r_d     = '0;
                        c_d     = '0;
                        base_d  = '0;
                    end else begin
                        base_d = base_q + BASE_INC;
                        if (c_q == C_MAX) begin
                            c_d = '0;
                            if (r_q == R_MAX) begin
                                r_d = '0;
                                k_d = k_q + CHAN_W'(1);
                            end else begin
                                r_d = r_q + RW'(1);
                            end
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags describe the element the counters will point at after this
        // edge; they are zero whenever no element is being presented.
        stream_d   = (state_d == S_STREAM);
        last_row_d = stream_d && (c_d == C_MAX);
        last_map_d = last_row_d && (r_d == R_MAX);
        last_d     = last_map_d && (k_d == K_MAX);
    end

    // State, counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            base_q     <= '0;
            last_row_q <= 1'b0;
            last_map_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            r_q        <= r_d;
            c_q        <= c_d;
            base_q     <= base_d;
            last_row_q <= last_row_d;
            last_map_q <= last_map_d;
            last_q     <= last_d;
        end
    end

    // Element select straight off the live bus, forced to zero when idle.
    always_comb begin
        out_data = '0;
        if (state_q == S_STREAM) begin
            out_data = fmap[base_q +: DATA_WIDTH];
        end
    end

    assign out_valid    = (state_q == S_STREAM);
    assign busy         = (state_q == S_STREAM);
    assign done         = (state_q == S_FINISH);
    assign out_chan     = k_q;
    assign out_last_row = last_row_q;
    assign out_last_map = last_map_q;
    assign out_last     = last_q;

endmodule
